// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute/
// memory/writeback per opcode and drives every datapath select and write enable.
module multicycle_control_fsm #(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    input  logic                    Zero,
    input  logic                    MemReady,
    output logic                    PCWrite,
    output logic                    PCWriteCond,
    output logic                    IorD,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    IRWrite,
    output logic                    MemToReg,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              PCSource,
    output logic                    Illegal,
    output logic [STATE_WIDTH-1:0]  State
);

    localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'b111111);

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH  = STATE_WIDTH'(0),
        S_DECODE = STATE_WIDTH'(1),
        S_MEMADR = STATE_WIDTH'(2),
        S_MEMRD  = STATE_WIDTH'(3),
        S_MEMWB  = STATE_WIDTH'(4),
        S_MEMWR  = STATE_WIDTH'(5),
        S_EXECR  = STATE_WIDTH'(6),
        S_RWB    = STATE_WIDTH'(7),
        S_EXECI  = STATE_WIDTH'(8),
        S_IWB    = STATE_WIDTH'(9),
        S_BRANCH = STATE_WIDTH'(10),
        S_JUMP   = STATE_WIDTH'(11),
        S_HALT   = STATE_WIDTH'(12)
    } state_t;

    state_t state_q, state_d;

    // Branch qualification happens in the datapath via PCWriteCond.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        Illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b10;
                unique case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_ADDI:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT:      state_d = S_HALT;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every control output so nothing is written while held.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-opcode state sequences with
// random memory stalls, checked against a spec-derived control table.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int errs   = 0;
    int checks = 0;

    multicycle_control_fsm #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    wire [16:0] ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word expected in state s, straight from the per-state output lists.
    function automatic logic [16:0] exp_ctl(input int s, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            1:  asb = 2'b10;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; asb = 2'b10; end
            9:  rw = 1;
            10: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            11: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Entered 1 time unit after a rising edge; leaves at the same phase of the next.
    task automatic cycle(input int s, input logic rdy, input logic ill);
        MemReady = rdy;
        Zero     = 1'($urandom);
        #1;
        check("state", 32'(State), 32'(s));
        check("ctl", 32'(ctl), 32'(exp_ctl(s, rdy, ill)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] opc);
        int   seq[$];
        logic illg;
        illg   = 1'b0;
        Opcode = opc;
        case (opc)
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 8, 9};
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000100: seq = '{0, 1, 10};
            6'b000010: seq = '{0, 1, 11};
            6'b111111: seq = '{0, 1, 12};
            default: begin seq = '{0, 1}; illg = 1'b1; end
        endcase
        foreach (seq[i]) begin
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
                int   n;
                logic rdy;
                n = 0;
                do begin
                    rdy = ($urandom_range(0, 2) != 0) || (n >= 5);
                    cycle(seq[i], rdy, 1'b0);
                    n++;
                end while (!rdy);
            end else begin
                cycle(seq[i], 1'($urandom), illg && (seq[i] == 1));
            end
        end
    endtask

    function automatic logic [5:0] pick_opcode();
        logic [5:0] ops [8];
        logic [5:0] o;
        ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
                6'b000100, 6'b000010, 6'b010101, 6'b000000};
        o = ops[$urandom_range(0, 7)];
        if (o == 6'b010101) begin
            o = 6'($urandom);
            if (o inside {6'b000000, 6'b001000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b111111})
                o = 6'b010101;
        end
        return o;
    endfunction

    initial begin
        rst_n    = 1'b0;
        MemReady = 1'b1;
        Opcode   = 6'b000000;
        Zero     = 1'b0;

        // Reset from power-up state: outputs masked, State lands on FETCH.
        @(posedge clk); #1;
        check("rst_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_ctl2", 32'(ctl), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_memread", 32'(MemRead), 32'd1);
        check("rel_alusrcb", 32'(ALUSrcB), 32'd1);

        // Directed opcodes first, then a random instruction stream.
        run_instr(6'b000000);
        run_instr(6'b100011);
        run_instr(6'b101011);
        run_instr(6'b000100);
        run_instr(6'b010101);
        run_instr(6'b001000);
        run_instr(6'b000010);
        for (int k = 0; k < 60; k++) begin
            run_instr(pick_opcode());
        end

        // Reset while stalled in MEMRD.
        Opcode = 6'b100011;
        cycle(0, 1'b1, 1'b0);
        cycle(1, 1'b0, 1'b0);
        cycle(2, 1'b0, 1'b0);
        MemReady = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_state", 32'(State), 32'd3);
        check("midrst_ctl", 32'(ctl), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(0, 1'b0, 1'b0);

        // HALT holds with all outputs low until reset.
        run_instr(6'b000000);
        run_instr(6'b111111);
        for (int k = 0; k < 20; k++) begin
            Opcode = 6'($urandom);
            cycle(12, 1'($urandom), 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(0, 1'b1, 1'b0);
        Opcode = 6'b001000;
        cycle(1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
